// File: rtl/video_pattern_source.sv
// video_pattern_source
//   Free-running raster generator producing de/hsync/vsync and a 24-bit
//   {R,G,B} test pattern with well-known edges. It lets downstream filter
//   stages be exercised without a camera or HDMI source.
//
// Ports
//   clk          pixel clock, rising edge
//   rst          asynchronous reset, active low
//   en           run enable; low idles the stream and rewinds to pixel (0,0)
//   pattern_sel  0 colour bars, 1 gray ramp, 2 checkerboard, 3 vertical edge
//   de           data enable, high on active pixels
//   hsync/vsync  sync pulses, active level set by SYNC_POL
//   pixel_out    {R,G,B}; forced to 0 whenever de is low
//   frame_start  one-cycle pulse coincident with pixel (0,0)
//
// All outputs are registered from the current counter values on the same
// edge that advances the counters, so outputs lag the counters by one clock.
module video_pattern_source #(
  parameter int H_ACTIVE   = 64,
  parameter int H_FP       = 4,
  parameter int H_SYNC     = 8,
  parameter int H_BP       = 7,
  parameter int V_ACTIVE   = 48,
  parameter int V_FP       = 2,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 7,
  parameter int SYNC_POL   = 1,
  parameter int RAMP_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] pixel_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Widths hold H_TOTAL itself (not just H_TOTAL-1) so the sync-end bound
  // never truncates; minimum of 4 bits because the checkerboard uses bit 3.
  localparam int HW = ($clog2(H_TOTAL + 1) < 4) ? 4 : $clog2(H_TOTAL + 1);
  localparam int VW = ($clog2(V_TOTAL + 1) < 4) ? 4 : $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_HALF   = HW'(H_ACTIVE / 2);
  localparam logic [HW-1:0] BAR_W    = HW'(H_ACTIVE / 8);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [HW-1:0] h_cnt_reg, h_cnt_next;
  logic [VW-1:0] v_cnt_reg, v_cnt_next;
  logic [1:0]    pattern_reg, pattern_next;

  logic          de_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          frame_start_next;
  logic [23:0]   pixel_next;

  logic          at_origin;
  logic [2:0]    bar;
  logic [2:0]    channel_on;
  logic [23:0]   bars_rgb;
  logic [7:0]    ramp_g;

  // Colour bar index and per-channel enables. Walking bars 0..7 gives
  // white, yellow, cyan, green, magenta, red, blue, black, which is
  // R = ~bar[1], G = ~bar[2], B = ~bar[0].
  assign bar        = 3'(h_cnt_reg / BAR_W);
  assign channel_on = {~bar[1], ~bar[2], ~bar[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bar_chan
      assign bars_rgb[gi*8 +: 8] = {8{channel_on[gi]}};
    end
  endgenerate

  // Widen before shifting so high ramp bits are not lost, then keep 8 bits.
  assign ramp_g = 8'({8'd0, h_cnt_reg} << RAMP_SHIFT);

  always_comb begin
    h_cnt_next       = h_cnt_reg + HW'(1);
    v_cnt_next       = v_cnt_reg;
    at_origin        = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    pattern_next     = pattern_reg;
    de_next          = 1'b0;
    hsync_next       = ~SYNC_ON;
    vsync_next       = ~SYNC_ON;
    frame_start_next = 1'b0;
    pixel_next       = 24'h000000;

    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + VW'(1);
    end

    // The selection is sampled at the frame origin and used for that very
    // pixel too, so a whole frame always shows a single pattern.
    if (at_origin) begin
      pattern_next = pattern_sel;
    end

    de_next          = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    frame_start_next = at_origin;
    if ((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END)) begin
      hsync_next = SYNC_ON;
    end
    if ((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END)) begin
      vsync_next = SYNC_ON;
    end

    if (de_next) begin
      case (pattern_next)
        2'd0:    pixel_next = bars_rgb;
        2'd1:    pixel_next = {ramp_g, ramp_g, ramp_g};
        2'd2:    pixel_next = (h_cnt_reg[3] ^ v_cnt_reg[3]) ? 24'hFFFFFF : 24'h000000;
        default: pixel_next = (h_cnt_reg < H_HALF) ? 24'h000000 : 24'hFFFFFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      pattern_reg <= 2'd0;
      de          <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      frame_start <= 1'b0;
      pixel_out   <= 24'h000000;
    end else if (!en) begin
      // Idle: rewind to the origin so the next enabled edge emits (0,0).
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      frame_start <= 1'b0;
      pixel_out   <= 24'h000000;
    end else begin
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
      pattern_reg <= pattern_next;
      de          <= de_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      frame_start <= frame_start_next;
      pixel_out   <= pixel_next;
    end
  end

endmodule

// File: tb/tb_video_pattern_source.sv
// Testbench for video_pattern_source (default parameters).
// Stimulus pushes expected output snapshots {de,hsync,vsync,frame_start,pixel}
// tagged with the negedge index at which they must appear; a monitor on every
// negedge pops and compares matching entries and also measures raster timing.
module tb_video_pattern_source;

  localparam int LINE  = 83;
  localparam int FRAME = 4980;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pattern_sel;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [23:0] pixel_out;
  logic        frame_start;

  video_pattern_source dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pattern_sel (pattern_sel),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .pixel_out   (pixel_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    string       name;
    logic [27:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;
  bit   stats_on = 1'b0;
  int   f0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic push(input string name, input int at, input bit e_de, input bit e_hs,
                      input bit e_vs, input bit e_fs, input logic [23:0] e_pix);
    exp_t e;
    e.at   = at;
    e.name = name;
    e.val  = {e_de, e_hs, e_vs, e_fs, e_pix};
    sb_q.push_back(e);
  endtask

  // Absolute negedge index of pixel (h,v) in frame fr after release.
  function automatic int pos(input int fr, input int h, input int v);
    return f0 + fr * FRAME + v * LINE + h;
  endfunction

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: scoreboard compare plus raster timing measurement.
  int  last_fs = 0, de_cnt = 0, vs_cnt = 0, de_rise = -100000, hs_rise = 0;
  bit  have_fs = 1'b0, hs_seen = 1'b0, de_p = 1'b0, hs_p = 1'b0;

  always @(negedge clk) begin
    logic [27:0] act;
    cyc++;
    act = {de, hsync, vsync, frame_start, pixel_out};
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].at == cyc) begin
        $display("check %-12s cycle %0d de=%b hs=%b vs=%b fs=%b pix=%h", sb_q[i].name, cyc,
                 de, hsync, vsync, frame_start, pixel_out);
        chk(sb_q[i].name, int'(act), int'(sb_q[i].val));
        sb_q.delete(i);
      end
    end
    if (stats_on) begin
      if (frame_start) begin
        if (have_fs) begin
          chk("fs_period", cyc - last_fs, FRAME);
          chk("de_per_frame", de_cnt, 3072);
          chk("vs_per_frame", vs_cnt, 249);
        end
        have_fs = 1'b1;
        last_fs = cyc;
        de_cnt  = 0;
        vs_cnt  = 0;
      end
      if (de) de_cnt++;
      if (vsync) vs_cnt++;
      if (de && !de_p) de_rise = cyc;
      if (!de && de_p) chk("de_width", cyc - de_rise, 64);
      if (hsync && !hs_p) begin
        hs_rise = cyc;
        hs_seen = 1'b1;
        if (cyc - de_rise < LINE) chk("hs_after_de", cyc - de_rise, 68);
      end
      if (!hsync && hs_p && hs_seen) chk("hs_width", cyc - hs_rise, 8);
    end
    de_p = de;
    hs_p = hsync;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst = 1'b0;
    en = 1'b0;
    pattern_sel = 2'd0;

    // Reset held, including with en high.
    wait_cyc(3);
    push("rst_idle", cyc + 1, 0, 0, 0, 0, 24'h000000);
    en = 1'b1;
    push("rst_en_idle", cyc + 2, 0, 0, 0, 0, 24'h000000);
    wait_cyc(6);

    // Release: first edge presents pixel (0,0).
    f0 = cyc + 1;
    rst = 1'b1;
    stats_on = 1'b1;
    push("f1_origin",  pos(0, 0, 0),   1, 0, 0, 1, 24'hFFFFFF);
    push("bar1",       pos(0, 8, 0),   1, 0, 0, 0, 24'hFFFF00);
    push("bar7",       pos(0, 63, 0),  1, 0, 0, 0, 24'h000000);
    push("hblank",     pos(0, 64, 0),  0, 0, 0, 0, 24'h000000);
    push("hs_start",   pos(0, 68, 0),  0, 1, 0, 0, 24'h000000);
    push("hs_last",    pos(0, 75, 0),  0, 1, 0, 0, 24'h000000);
    push("hs_end",     pos(0, 76, 0),  0, 0, 0, 0, 24'h000000);
    push("bar2_l10",   pos(0, 16, 10), 1, 0, 0, 0, 24'h00FFFF);
    push("bar5_l20",   pos(0, 40, 20), 1, 0, 0, 0, 24'hFF0000);
    push("vblank_l48", pos(0, 0, 48),  0, 0, 0, 0, 24'h000000);
    push("vs_first",   pos(0, 0, 50),  0, 0, 1, 0, 24'h000000);
    push("vs_hsync",   pos(0, 70, 51), 0, 1, 1, 0, 24'h000000);
    push("vs_last",    pos(0, 82, 52), 0, 0, 1, 0, 24'h000000);
    push("vs_off",     pos(0, 0, 53),  0, 0, 0, 0, 24'h000000);

    // Mid-frame change to vertical edge: applies from frame 2.
    wait_cyc(pos(0, 0, 10));
    pattern_sel = 2'd3;
    push("edge_fs",    pos(1, 0, 0),   1, 0, 0, 1, 24'h000000);
    push("edge31",     pos(1, 31, 0),  1, 0, 0, 0, 24'h000000);
    push("edge32",     pos(1, 32, 0),  1, 0, 0, 0, 24'hFFFFFF);
    push("edge32_l47", pos(1, 32, 47), 1, 0, 0, 0, 24'hFFFFFF);
    push("edge31_l47", pos(1, 31, 47), 1, 0, 0, 0, 24'h000000);

    wait_cyc(pos(1, 0, 10));
    pattern_sel = 2'd1;
    push("ramp_fs",    pos(2, 0, 0),   1, 0, 0, 1, 24'h000000);
    push("ramp10",     pos(2, 10, 0),  1, 0, 0, 0, 24'h282828);
    push("ramp63",     pos(2, 63, 0),  1, 0, 0, 0, 24'hFCFCFC);
    push("ramp10_l30", pos(2, 10, 30), 1, 0, 0, 0, 24'h282828);

    wait_cyc(pos(2, 0, 10));
    pattern_sel = 2'd2;
    push("chk_8_0",    pos(3, 8, 0),   1, 0, 0, 0, 24'hFFFFFF);
    push("chk_8_8",    pos(3, 8, 8),   1, 0, 0, 0, 24'h000000);
    push("chk_0_8",    pos(3, 0, 8),   1, 0, 0, 0, 24'hFFFFFF);
    push("chk_15_15",  pos(3, 15, 15), 1, 0, 0, 0, 24'h000000);
    push("chk_16_15",  pos(3, 16, 15), 1, 0, 0, 0, 24'hFFFFFF);
    push("chk_64_8",   pos(3, 64, 8),  0, 0, 0, 0, 24'h000000);

    wait_cyc(pos(3, 0, 10));
    pattern_sel = 2'd0;

    // Drop en so that pixel (30,5) of frame 5 is never emitted.
    wait_cyc(pos(4, 10, 0));
    stats_on = 1'b0;
    c = pos(4, 29, 5);
    wait_cyc(c);
    en = 1'b0;
    push("en_off_1",   c + 1,  0, 0, 0, 0, 24'h000000);
    push("en_off_10",  c + 10, 0, 0, 0, 0, 24'h000000);
    push("en_off_20",  c + 20, 0, 0, 0, 0, 24'h000000);
    wait_cyc(c + 20);
    en = 1'b1;
    push("restart_fs", c + 21, 1, 0, 0, 1, 24'hFFFFFF);
    push("restart_h1", c + 22, 1, 0, 0, 0, 24'hFFFFFF);
    push("restart_h8", c + 29, 1, 0, 0, 0, 24'hFFFF00);
    push("restart_hs", c + 21 + 68, 0, 1, 0, 0, 24'h000000);
    wait_cyc(c + 120);

    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      $display("FAIL %s: got no sample, expected %0h at cycle %0d", e.name, e.val, e.at);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
